iq_dec_accum: RTL
=================

// Module: iq_dec_accum
// PURPOSE
//  Downstream consumer of the 3-bit DDS cos/sin sample stream (data_valid-qualified).
//  Integrate-and-dump decimator: sums DEC consecutive valid signed I/Q samples, emits one
//  widened I/Q word per block through a 1-deep valid/ready output register.
//  No backpressure to upstream; output overrun is flagged, never stalls the source.
// PARAMETERS
//  IN_W   3   input sample width, signed two's complement
//  DEC    16  decimation ratio; power of two, 2..256
//  ACC_W  IN_W+$clog2(DEC)  derived localparam: accumulator/output width, exact, no saturation
// PORTS
//  clk        in   1      sole clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  clr        in   1      synchronous restart: zero accumulators and counter, keep output reg
//  in_valid   in   1      sample strobe (from upstream data_valid)
//  in_i       in   IN_W   I sample (cos), signed
//  in_q       in   IN_W   Q sample (sin), signed
//  out_i      out  ACC_W  decimated I sum, signed
//  out_q      out  ACC_W  decimated Q sum, signed
//  out_valid  out  1      output word held
//  out_ready  in   1      downstream accept
//  overrun    out  1      sticky: a dump found the output register still occupied
//  blk_cnt    out  8      count of dumped blocks, wraps 255->0
// BEHAVIOUR
//  - Reset: all outputs, accumulators, sample counter 0; FSM -> ACCUM.
//  - FSM: ACCUM (collecting), DUMP (internal, zero-cycle decision at the DEC-th sample edge).
//    Implemented as sample counter cnt 0..DEC-1 plus output-register full bit.
//  - Accept: edge with in_valid=1 and clr=0. acc <= acc + sext(in); cnt <= cnt+1.
//  - Dump: accepted sample with cnt==DEC-1: sum = acc + sext(in) (includes that sample);
//    acc <= 0, cnt <= 0 same edge; no sample lost, next valid starts new block.
//  - Latency: out_valid rises the edge the DEC-th sample is accepted (visible next cycle).
//  - Output: transfer on out_valid && out_ready -> out_valid <= 0, data held (don't-care).
//    out_i/out_q stable while out_valid=1 and out_ready=0.
//  - Dump with out_valid=0, or out_valid=1 && out_ready=1 same edge: load sum, out_valid=1,
//    blk_cnt+1, no overrun.
//  - Dump with out_valid=1 && out_ready=0: new sum DROPPED, old word kept, overrun <= 1,
//    blk_cnt still +1. overrun clears only on rst.
//  - clr=1: acc, cnt <= 0; any in_valid that edge discarded; out_valid/out_i/out_q/overrun
//    unchanged, output handshake still honoured.
//  - Width: sext IN_W->ACC_W; range -4*DEC..3*DEC (IN_W=3) fits ACC_W exactly.
//  - in_valid gaps of any length allowed; block boundaries count valid samples only.
//  - rst mid-block: partial sum discarded, nothing emitted.
// STRUCTURE
//  - Package iq_dec_pkg: IN_W, DEC defaults, ACC_W function, sign-extend function.
//  - Sub-module iq_dec_lane: one signed accumulator + dump register; instantiated for I, Q.
//    Counter, handshake, overrun, blk_cnt live in top.
// TESTING
//  1 rst mid-run -> all outputs 0, next out_valid only after 16 new valid samples.
//  2 16 valid samples in_i=+3, in_q=-4, out_ready=1 -> out_i=48, out_q=-64, 1 cycle after
//    16th, blk_cnt=1.
//  3 in_valid every 3rd cycle, alternating +1/-1 -> out_i=0 per block, block spans 48 cycles.
//  4 out_ready=0 across two blocks of +1 -> out_i stays 16, overrun=1, blk_cnt=2;
//    raise out_ready -> one transfer, out_valid=0.
//  5 dump edge coincides with out_ready=1 -> new word loaded, out_valid stays 1, overrun=0.
//  6 clr with in_valid at sample 10 -> sample dropped; next 16 samples form block;
//    held output word untouched.

Source files
------------

// File: rtl/iq_dec_pkg.sv
// rtl/iq_dec_pkg.sv - shared widths and helpers for the I/Q integrate-and-dump decimator
package iq_dec_pkg;

  localparam int IN_W_DEF = 3;
  localparam int DEC_DEF  = 16;

  // Accumulator width that holds DEC full-scale samples exactly.
  function automatic int acc_width(input int in_w, input int dec);
    return in_w + $clog2(dec);
  endfunction

  localparam int ACC_W_DEF = acc_width(IN_W_DEF, DEC_DEF);

  function automatic logic signed [ACC_W_DEF-1:0] sext(input logic signed [IN_W_DEF-1:0] v);
    return ACC_W_DEF'(v);
  endfunction

endpackage

// File: rtl/iq_dec_accum_if.sv
// rtl/iq_dec_accum_if.sv - sample input strobe and decimated valid/ready output word
interface iq_dec_accum_if #(
  parameter int IN_W  = 3,
  parameter int ACC_W = 7
);

  logic                    in_valid;
  logic signed [IN_W-1:0]  in_i;
  logic signed [IN_W-1:0]  in_q;
  logic signed [ACC_W-1:0] out_i;
  logic signed [ACC_W-1:0] out_q;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output in_valid, in_i, in_q, out_ready,
    input  out_i, out_q, out_valid
  );

  modport slave (
    input  in_valid, in_i, in_q, out_ready,
    output out_i, out_q, out_valid
  );

endinterface

// File: rtl/iq_dec_lane.sv
// rtl/iq_dec_lane.sv - one signed accumulator with its dump register
import iq_dec_pkg::*;

module iq_dec_lane #(
  parameter int IN_W  = IN_W_DEF,
  parameter int ACC_W = acc_width(IN_W_DEF, DEC_DEF)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    accept,
  input  logic                    dump,
  input  logic                    load,
  input  logic signed [IN_W-1:0]  sample,
  output logic signed [ACC_W-1:0] sum
);

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_nxt;

  // The dumped sum includes the sample accepted on the dump edge.
  assign acc_nxt = acc + ACC_W'(sample);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      sum <= '0;
    end else begin
      if (clr || (accept && dump)) begin
        acc <= '0;
      end else if (accept) begin
        acc <= acc_nxt;
      end
      if (load) begin
        sum <= acc_nxt;
      end
    end
  end

endmodule

// File: rtl/iq_dec_accum.sv
// rtl/iq_dec_accum.sv - I/Q integrate-and-dump decimator with 1-deep output register
import iq_dec_pkg::*;

module iq_dec_accum #(
  parameter int IN_W = IN_W_DEF,
  parameter int DEC  = DEC_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  iq_dec_accum_if.slave bus,
  output logic         overrun,
  output logic [7:0]   blk_cnt
);

  localparam int ACC_W = acc_width(IN_W, DEC);
  localparam int CNT_W = $clog2(DEC);

  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             dump;
  logic             load;

  assign accept = bus.in_valid && !clr;
  assign dump   = accept && (cnt == CNT_W'(DEC - 1));
  // A dump only lands if the output slot is empty or emptying this edge.
  assign load   = dump && (!bus.out_valid || bus.out_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt           <= '0;
      bus.out_valid <= 1'b0;
      overrun       <= 1'b0;
      blk_cnt       <= 8'd0;
    end else begin
      if (clr) begin
        cnt <= '0;
      end else if (accept) begin
        cnt <= dump ? '0 : cnt + CNT_W'(1);
      end
      if (load) begin
        bus.out_valid <= 1'b1;
      end else if (bus.out_valid && bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
      if (dump) begin
        blk_cnt <= blk_cnt + 8'd1;
        if (!load) begin
          overrun <= 1'b1;
        end
      end
    end
  end

  iq_dec_lane #(.IN_W(IN_W), .ACC_W(ACC_W)) u_lane_i (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .accept (accept),
    .dump   (dump),
    .load   (load),
    .sample (bus.in_i),
    .sum    (bus.out_i)
  );

  iq_dec_lane #(.IN_W(IN_W), .ACC_W(ACC_W)) u_lane_q (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .accept (accept),
    .dump   (dump),
    .load   (load),
    .sample (bus.in_q),
    .sum    (bus.out_q)
  );

endmodule
